// File: rtl/hex_display_scan.sv
// Time-multiplexed DIGITS-wide hex display driver with leading-zero blanking and an
// anti-ghost blank cycle per digit slot. Optional blinking is enabled by HEX_BLINK_EN.
module hex_display_scan #(
  parameter int DIGITS      = 4,
`ifdef HEX_BLINK_EN
  parameter int BLINK_DIV   = 2**24,
`endif
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic                blank_lz,
`ifdef HEX_BLINK_EN
  input  logic [DIGITS-1:0]   blink_mask,
`endif
  output logic                load_ack,
  output logic [DIGITS-1:0]   digit_en,
  output logic [6:0]          segments
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Active-low {g..a} pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      4'hF:    seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                load_ack_q, load_ack_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic [6:0]          segments_q, segments_d;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic                zero_above;
`ifdef HEX_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
`endif

  // State and output registers; reset overrides load.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q      <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      load_ack_q    <= 1'b0;
      digit_en_q    <= '1;
      segments_q    <= 7'h7F;
`ifdef HEX_BLINK_EN
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
`endif
    end else begin
      shadow_q      <= shadow_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      load_ack_q    <= load_ack_d;
      digit_en_q    <= digit_en_d;
      segments_q    <= segments_d;
`ifdef HEX_BLINK_EN
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
`endif
    end
  end

  // Next state: shadow latch, slot counter and digit index.
  always_comb begin
    shadow_d   = load ? value : shadow_q;
    load_ack_d = load;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end
`ifdef HEX_BLINK_EN
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
      blink_phase_d = blink_phase_q;
    end
`endif
  end

  // Output decode: blank slot, digit select, leading-zero and blink suppression.
  always_comb begin
    cur_nib    = 4'h0;
    cur_blank  = 1'b0;
    zero_above = 1'b1;
    digit_en_d = '1;
    segments_d = 7'h7F;
    // Walk from the most significant digit so zero_above covers nibbles DIGITS-1..i.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (shadow_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = shadow_q[4*i +: 4];
        cur_blank = blank_lz & zero_above & (i != 0);
`ifdef HEX_BLINK_EN
        cur_blank = cur_blank | (blink_phase_q & blink_mask[i]);
`endif
      end else begin
        cur_blank = cur_blank;
      end
    end
    if (cnt_q != CNT_W'(0)) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_en_d[i] = (idx_q == IDX_W'(i)) ? 1'b0 : 1'b1;
      end
      segments_d = cur_blank ? 7'h7F : seg7(cur_nib);
    end else begin
      digit_en_d = '1;
      segments_d = 7'h7F;
    end
  end

  assign load_ack = load_ack_q;
  assign digit_en = digit_en_q;
  assign segments = segments_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench for hex_display_scan (DIGITS=4, REFRESH_DIV=4, BLINK_DIV=32).
// Expected outputs are derived from cycles-since-reset and a table of per-digit patterns.
module tb_hex_display_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_mask = 4'b0000;
  logic        load_ack;
  logic [3:0]  digit_en;
  logic [6:0]  segments;

  always #5 clk = ~clk;

  hex_display_scan #(
    .DIGITS      (4),
`ifdef HEX_BLINK_EN
    .BLINK_DIV   (32),
`endif
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .value      (value),
    .blank_lz   (blank_lz),
`ifdef HEX_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .load_ack   (load_ack),
    .digit_en   (digit_en),
    .segments   (segments)
  );

  typedef struct {
    logic [15:0]      value;
    logic             blz;
    logic [3:0][6:0]  seg;   // seg[d] = expected pattern of digit d
  } vec_t;

  typedef struct packed {
    logic       ack;
    logic [3:0] en;
    logic [6:0] seg;
  } exp_t;

  vec_t            vt [12];
  exp_t            q [$];
  logic [3:0][6:0] m_segs;
  int              m_k = 0;
  int              n_cmp = 0;
  int              n_bad = 0;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s k=%0d: got %h, expected %h", name, m_k, act, req);
    end
  endtask

  // One clock: predict the outputs of the coming edge, push, step, pop and compare.
  task automatic cycle(input logic rst, input logic ld, input int vi);
    exp_t e;
    int   pos;
    int   d;
    reset = rst;
    load  = ld;
    value = vt[vi].value;
    if (rst) begin
      e      = '{ack: 1'b0, en: 4'hF, seg: 7'h7F};
      m_k    = 0;
      m_segs = {7'h40, 7'h40, 7'h40, 7'h40};
    end else begin
      pos   = m_k % 4;
      d     = (m_k / 4) % 4;
      e.ack = ld;
      if (pos == 0) begin
        e.en  = 4'hF;
        e.seg = 7'h7F;
      end else begin
        e.en  = ~(4'b0001 << d);
        e.seg = m_segs[d];
`ifdef HEX_BLINK_EN
        if (blink_mask[d] && ((m_k / 32) % 2 == 1)) e.seg = 7'h7F;
`endif
      end
      m_k++;
      if (ld) m_segs = vt[vi].seg;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("load_ack", {6'd0, load_ack}, {6'd0, e.ack});
    check("digit_en", {3'd0, digit_en}, {3'd0, e.en});
    check("segments", segments, e.seg);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
  endtask

  // Load a vector, then switch blank_lz to the vector's setting from the next cycle on.
  task automatic apply(input int vi, input int n);
    cycle(1'b0, 1'b1, vi);
    blank_lz = vt[vi].blz;
    run(n);
  endtask

  initial begin
    vt[0]  = '{16'h12AF, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
    vt[1]  = '{16'h0005, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
    vt[2]  = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vt[3]  = '{16'h0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
    vt[4]  = '{16'h0F00, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40}};
    vt[5]  = '{16'hC3D0, 1'b1, {7'h46, 7'h30, 7'h21, 7'h40}};
    vt[6]  = '{16'h8765, 1'b0, {7'h00, 7'h78, 7'h02, 7'h12}};
    vt[7]  = '{16'h0005, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}};
    vt[8]  = '{16'h9BE4, 1'b1, {7'h10, 7'h03, 7'h06, 7'h19}};
    vt[9]  = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vt[10] = '{16'h0030, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}};
    vt[11] = '{16'h1234, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}};

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);

    apply(0, 20);
    for (int vi = 1; vi <= 11; vi++) apply(vi, 13 + vi);

    // Back-to-back loads: each sampled cycle writes and acks.
    apply(3, 6);
    cycle(1'b0, 1'b1, 6);
    cycle(1'b0, 1'b1, 9);
    cycle(1'b0, 1'b1, 9);
    run(18);

    // blank_lz acts live, without a new load.
    apply(7, 10);
    blank_lz = 1'b1;
    m_segs   = vt[1].seg;
    run(17);
    blank_lz = 1'b0;
    m_segs   = vt[7].seg;
    run(6);

    // Reset wins over a simultaneous load, then reset while digit 2 is lit.
    cycle(1'b1, 1'b1, 0);
    cycle(1'b1, 1'b0, 0);
    apply(0, 9);
    cycle(1'b1, 1'b0, 0);
    run(20);

`ifdef HEX_BLINK_EN
    blink_mask = 4'b0001;
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    apply(9, 140);
    blink_mask = 4'b0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
